vend_dispense_ctrl: RTL and testbench

- Sequences the physical dispense after a sale is granted: takes the one-cycle vend grant from the vending FSM, checks per-product stock, then drives one motor and waits for the drop sensor.
- Then pays out change as unit coins, or refunds on sold-out or jam.
- Sits between the vending FSM and the motor, sensor and coin-hopper I/O.

---
 rtl/vend_pkg.sv | 44 ++++
 rtl/vend_coin_pulser.sv | 55 +++++
 rtl/vend_dispense_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: product codes, prices and dispense-sequencer state encoding
// shared by the dispense controller and its coin pulser.
package vend_pkg;

  localparam logic [1:0] PROD_NONE = 2'd0;
  localparam logic [1:0] PROD_A    = 2'd1;
  localparam logic [1:0] PROD_B    = 2'd2;
  localparam logic [1:0] PROD_C    = 2'd3;

  localparam logic [3:0] COST_A = 4'd4;
  localparam logic [3:0] COST_B = 4'd7;
  localparam logic [3:0] COST_C = 4'd9;

  // Refund counts reach at most COST_C + 3 = 12 units.
  localparam int REFUND_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MOTOR,
    WAIT_DROP,
    PAYOUT,
    DONE
  } state_e;

  function automatic logic [3:0] cost_of(input logic [1:0] prod);
    case (prod)
      PROD_A:  cost_of = COST_A;
      PROD_B:  cost_of = COST_B;
      PROD_C:  cost_of = COST_C;
      default: cost_of = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] prod_onehot(input logic [1:0] prod);
    case (prod)
      PROD_A:  prod_onehot = 3'b001;
      PROD_B:  prod_onehot = 3'b010;
      PROD_C:  prod_onehot = 3'b100;
      default: prod_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_pulser.sv
// vend_coin_pulser: pays out a loaded number of unit coins as
// COIN_PULSE-high / COIN_PULSE-low pulses; finished is high whenever no
// coins remain owed.
module vend_coin_pulser
  import vend_pkg::*;
#(
  parameter int COIN_PULSE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [REFUND_W-1:0] load_cnt,
  output logic                coin_eject,
  output logic                finished
);

  localparam int PH_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(COIN_PULSE - 1);

  logic [REFUND_W-1:0] cnt_q;
  logic [PH_W-1:0]     phase_q;
  logic                high_q;
  logic                active;

  assign active     = (cnt_q != '0);
  assign coin_eject = active && high_q;
  assign finished   = !active;

  // Walk each coin through its high phase then its low gap; the count only
  // drops once the gap has completed so the last coin also gets its gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= '0;
      high_q  <= 1'b0;
    end else if (load) begin
      cnt_q   <= load_cnt;
      phase_q <= '0;
      high_q  <= 1'b1;
    end else if (active) begin
      if (phase_q == PH_LAST) begin
        phase_q <= '0;
        if (high_q) begin
          high_q <= 1'b0;
        end else begin
          high_q <= 1'b1;
          cnt_q  <= cnt_q - REFUND_W'(1);
        end
      end else begin
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: sequences a granted sale through stock check, motor
// drive, drop detection and change/refund payout. Optional audit counters
// (sales_cnt, refund_total) are built when AUDIT_COUNTERS_EN is defined.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 32,
  parameter int COIN_PULSE   = 4,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_valid,
  input  logic [1:0] vend_prod,
  input  logic [1:0] vend_change,
  input  logic       drop_sensor,
  input  logic       restock,
  input  logic [1:0] restock_sel,
  input  logic       fault_clr,
  output logic [2:0] motor,
  output logic       coin_eject,
  output logic       busy,
  output logic       done,
  output logic       sold_out,
  output logic       jam_fault,
  output logic       vend_lost,
  output logic [2:0] stock_empty
`ifdef AUDIT_COUNTERS_EN
  ,
  output logic [15:0] sales_cnt,
  output logic [15:0] refund_total
`endif
);

  localparam int TMR_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]   MOTOR_LAST   = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(DROP_TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] STOCK_INIT_V = STOCK_W'(STOCK_INIT);

  state_e              state_q, state_d;
  logic [1:0]          prod_q;
  logic [1:0]          change_q;
  logic [TMR_W-1:0]    timer_q;
  logic                jam_q;
  logic [STOCK_W-1:0]  stock_q [3];
  logic [STOCK_W-1:0]  cur_stock;
  logic                accept;
  logic                pay_load;
  logic [REFUND_W-1:0] pay_cnt;
  logic [REFUND_W-1:0] refund_full;
  logic                drop_ok;
  logic                timeout_hit;
  logic                restock_ok;
  logic                pay_finished;

  assign refund_full = {1'b0, cost_of(prod_q)} + {3'b000, change_q};
  assign restock_ok  = (state_q == IDLE) && restock && (restock_sel != PROD_NONE);

  // State register; an async reset abandons any dispense in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the product and change owed when a sale is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= PROD_NONE;
      change_q <= 2'd0;
    end else if (accept) begin
      prod_q   <= vend_prod;
      change_q <= vend_change;
    end
  end

  // Shared cycle timer for motor run time and drop wait, cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if ((state_q == MOTOR) || (state_q == WAIT_DROP)) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Sticky jam flag; a new timeout takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jam_q <= 1'b0;
    end else if (timeout_hit) begin
      jam_q <= 1'b1;
    end else if (fault_clr) begin
      jam_q <= 1'b0;
    end
  end

  // Per-product stock: reload only while idle, consume on a confirmed drop, never wrap below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        stock_q[i] <= STOCK_INIT_V;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (restock_ok && (restock_sel == 2'(i + 1))) begin
          stock_q[i] <= STOCK_INIT_V;
        end else if (drop_ok && (prod_q == 2'(i + 1)) && (stock_q[i] != '0)) begin
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
        end
      end
    end
  end

  // Select the stock counter of the latched product.
  always_comb begin
    cur_stock = '0;
    case (prod_q)
      PROD_A:  cur_stock = stock_q[0];
      PROD_B:  cur_stock = stock_q[1];
      PROD_C:  cur_stock = stock_q[2];
      default: cur_stock = '0;
    endcase
  end

  // Empty flags follow the counters directly.
  always_comb begin
    stock_empty = '0;
    for (int i = 0; i < 3; i++) begin
      stock_empty[i] = (stock_q[i] == '0);
    end
  end

  // Next-state logic; every entry into PAYOUT loads the pulser with the amount owed.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    pay_load    = 1'b0;
    pay_cnt     = '0;
    drop_ok     = 1'b0;
    timeout_hit = 1'b0;
    sold_out    = 1'b0;
    case (state_q)
      IDLE: begin
        if (vend_valid && (vend_prod != PROD_NONE)) begin
          accept  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (jam_q) begin
          pay_load = 1'b1;
          pay_cnt  = refund_full;
          state_d  = PAYOUT;
        end else if (cur_stock == '0) begin
          sold_out = 1'b1;
          pay_load = 1'b1;
          pay_cnt  = refund_full;
          state_d  = PAYOUT;
        end else begin
          state_d = MOTOR;
        end
      end
      MOTOR: begin
        if (timer_q == MOTOR_LAST) begin
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (drop_sensor) begin
          drop_ok  = 1'b1;
          pay_load = 1'b1;
          pay_cnt  = {3'b000, change_q};
          state_d  = PAYOUT;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          pay_load    = 1'b1;
          pay_cnt     = refund_full;
          state_d     = PAYOUT;
        end
      end
      PAYOUT: begin
        if (pay_finished) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign vend_lost = vend_valid && busy;
  assign jam_fault = jam_q;
  assign motor     = (state_q == MOTOR) ? prod_onehot(prod_q) : 3'b000;

  vend_coin_pulser #(
    .COIN_PULSE(COIN_PULSE)
  ) u_pulser (
    .clk       (clk),
    .rst       (rst),
    .load      (pay_load),
    .load_cnt  (pay_cnt),
    .coin_eject(coin_eject),
    .finished  (pay_finished)
  );

`ifdef AUDIT_COUNTERS_EN
  logic [16:0] refund_sum;

  assign refund_sum = {1'b0, refund_total} + 17'(pay_cnt);

  // Audit totals: wrapping sales count, saturating refunded-unit total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sales_cnt    <= '0;
      refund_total <= '0;
    end else begin
      if (drop_ok) begin
        sales_cnt <= sales_cnt + 16'd1;
      end
      if (pay_load && !drop_ok) begin
        refund_total <= refund_sum[16] ? 16'hFFFF : refund_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed and randomized transactions checked
// against a transaction-level model of stock, jam state and payout timing.
module tb_vend_dispense_ctrl;

  localparam int MC = 8;
  localparam int DT = 32;
  localparam int CP = 4;
  localparam int SI = 5;

  logic       clk;
  logic       rst;
  logic       vend_valid;
  logic [1:0] vend_prod;
  logic [1:0] vend_change;
  logic       drop_sensor;
  logic       restock;
  logic [1:0] restock_sel;
  logic       fault_clr;
  logic [2:0] motor;
  logic       coin_eject;
  logic       busy;
  logic       done;
  logic       sold_out;
  logic       jam_fault;
  logic       vend_lost;
  logic [2:0] stock_empty;
`ifdef AUDIT_COUNTERS_EN
  logic [15:0] sales_cnt;
  logic [15:0] refund_total;
  int          m_sales;
  int          m_refund;
`endif

  int n_cmp;
  int n_err;
  int m_stock [1:3];
  bit m_jam;

  vend_dispense_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vend_valid (vend_valid),
    .vend_prod  (vend_prod),
    .vend_change(vend_change),
    .drop_sensor(drop_sensor),
    .restock    (restock),
    .restock_sel(restock_sel),
    .fault_clr  (fault_clr),
    .motor      (motor),
    .coin_eject (coin_eject),
    .busy       (busy),
    .done       (done),
    .sold_out   (sold_out),
    .jam_fault  (jam_fault),
    .vend_lost  (vend_lost),
    .stock_empty(stock_empty)
`ifdef AUDIT_COUNTERS_EN
    ,
    .sales_cnt   (sales_cnt),
    .refund_total(refund_total)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] model_empty();
    return {m_stock[3] == 0, m_stock[2] == 0, m_stock[1] == 0};
  endfunction

  task automatic clearInputs();
    vend_valid  = 1'b0;
    vend_prod   = 2'd0;
    vend_change = 2'd0;
    drop_sensor = 1'b0;
    restock     = 1'b0;
    restock_sel = 2'd0;
    fault_clr   = 1'b0;
  endtask

  task automatic modelReset();
    for (int i = 1; i <= 3; i++) m_stock[i] = SI;
    m_jam = 1'b0;
`ifdef AUDIT_COUNTERS_EN
    m_sales  = 0;
    m_refund = 0;
`endif
  endtask

  // One transaction. drop_d: wait cycle of the drop (0 = never).
  // extra bits: 1 vend during busy, 2 restock A during busy, 4 drop pulse in
  // a motor cycle, 8 fault_clr on the timeout cycle. abort_k: reset after
  // sampling that cycle (0 = run to completion).
  task automatic applyStimulus(input string tag, input int prod, input int change,
                               input int drop_d, input int extra, input int abort_k);
    int cost, n, p, d, last;
    bit refund, sold, tmo, jam0;
    logic [2:0] oh;
    int e_motor, e_coin, e_busy, e_done, e_sold, e_lost, e_jam;
    bit ex_coin;
    cost   = (prod == 1) ? 4 : (prod == 2) ? 7 : 9;
    oh     = 3'(1 << (prod - 1));
    jam0   = m_jam;
    refund = m_jam || (m_stock[prod] == 0);
    sold   = !m_jam && (m_stock[prod] == 0);
    tmo    = !refund && (drop_d == 0);
    if (refund) begin
      n = cost + change; p = 2;
    end else if (!tmo) begin
      n = change; p = 2 + MC + drop_d;
    end else begin
      n = cost + change; p = 2 + MC + DT;
    end
    d    = p + 2 * CP * n + 1;
    last = (abort_k != 0) ? abort_k : d + 1;
    e_motor = 0; e_coin = 0; e_busy = 0; e_done = 0; e_sold = 0; e_lost = 0; e_jam = 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      vend_valid  = (k == 0) || (((extra & 1) != 0) && k == 4);
      vend_prod   = (k == 0) ? 2'(prod) : (((extra & 1) != 0) && k == 4) ? 2'd1 : 2'd0;
      vend_change = (k == 0) ? 2'(change) : 2'd0;
      drop_sensor = (!refund && drop_d > 0 && k >= 1 + MC + drop_d && k <= d) ||
                    (((extra & 4) != 0) && k == 5);
      restock     = ((extra & 2) != 0) && k == 5;
      restock_sel = restock ? 2'd1 : 2'd0;
      fault_clr   = ((extra & 8) != 0) && k == 1 + MC + DT;
      @(negedge clk);
      ex_coin = (k >= p) && (k < p + 2 * CP * n) && (((k - p) % (2 * CP)) < CP);
      if (motor !== ((!refund && k >= 2 && k <= 1 + MC) ? oh : 3'b000)) e_motor++;
      if (coin_eject !== ex_coin) e_coin++;
      if (busy !== (k >= 1 && k <= d)) e_busy++;
      if (done !== (k == d)) e_done++;
      if (sold_out !== (sold && k == 1)) e_sold++;
      if (vend_lost !== (((extra & 1) != 0) && k == 4)) e_lost++;
      if (jam_fault !== (jam0 || (tmo && k >= p))) e_jam++;
    end
    checkOutput({tag, "_motor_wave_errs"}, e_motor, 0);
    checkOutput({tag, "_coin_wave_errs"}, e_coin, 0);
    checkOutput({tag, "_busy_wave_errs"}, e_busy, 0);
    checkOutput({tag, "_done_wave_errs"}, e_done, 0);
    checkOutput({tag, "_sold_out_wave_errs"}, e_sold, 0);
    checkOutput({tag, "_vend_lost_wave_errs"}, e_lost, 0);
    checkOutput({tag, "_jam_wave_errs"}, e_jam, 0);
    if (abort_k != 0) begin
      #2 rst = 1'b1;
      #1;
      checkOutput({tag, "_abort_coin"}, coin_eject, 0);
      checkOutput({tag, "_abort_busy"}, busy, 0);
      checkOutput({tag, "_abort_motor"}, motor, 0);
      clearInputs();
      modelReset();
      checkOutput({tag, "_abort_empty"}, stock_empty, model_empty());
      @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      if (!refund && !tmo) m_stock[prod]--;
      if (tmo) m_jam = 1'b1;
`ifdef AUDIT_COUNTERS_EN
      if (!refund && !tmo) m_sales = (m_sales + 1) % 65536;
      if (refund || tmo) m_refund = (m_refund + n > 65535) ? 65535 : m_refund + n;
      checkOutput({tag, "_sales_cnt"}, sales_cnt, m_sales);
      checkOutput({tag, "_refund_total"}, refund_total, m_refund);
`endif
      checkOutput({tag, "_stock_empty"}, stock_empty, model_empty());
      clearInputs();
    end
  endtask

  // One idle cycle of restock / fault clear / invalid-product request.
  task automatic idleCycle(input string tag, input int sel, input bit clr, input bit bad_vend);
    @(posedge clk);
    #1;
    restock     = (sel != 0);
    restock_sel = 2'(sel);
    fault_clr   = clr;
    vend_valid  = bad_vend;
    vend_prod   = 2'd0;
    if (sel != 0) m_stock[sel] = SI;
    if (clr) m_jam = 1'b0;
    @(posedge clk);
    #1;
    clearInputs();
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_empty"}, stock_empty, model_empty());
    checkOutput({tag, "_idle_jam"}, jam_fault, m_jam);
  endtask

  initial begin
    int prod, change, drop_d, extra;
    n_cmp = 0;
    n_err = 0;
    clearInputs();
    modelReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_motor", motor, 0);
    checkOutput("reset_coin", coin_eject, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sold_out", sold_out, 0);
    checkOutput("reset_jam", jam_fault, 0);
    checkOutput("reset_vend_lost", vend_lost, 0);
    checkOutput("reset_empty", stock_empty, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] normal vend");
    applyStimulus("normal_b", 2, 3, 2, 0, 0);

    $display("[TB] sold out");
    for (int i = 0; i < 5; i++) applyStimulus("drain_a", 1, 0, 1, 0, 0);
    checkOutput("drained_a_empty", stock_empty[0], 1);
    applyStimulus("sold_out_a", 1, 1, 1, 0, 0);

    $display("[TB] jam and sticky fault");
    applyStimulus("jam_c", 3, 0, 0, 0, 0);
    applyStimulus("jam_sticky_a", 1, 2, 1, 0, 0);
    idleCycle("clr_jam", 0, 1'b1, 1'b0);
    applyStimulus("after_clr_b", 2, 0, 1, 0, 0);

    $display("[TB] overlap and restock");
    applyStimulus("overlap_b", 2, 1, 2, 1 | 2 | 4, 0);
    idleCycle("restock_a", 1, 1'b0, 1'b0);
    idleCycle("bad_prod", 0, 1'b0, 1'b1);
    applyStimulus("jam_clr_race_b", 2, 0, 0, 8, 0);
    idleCycle("clr_jam2", 0, 1'b1, 1'b0);

    $display("[TB] reset during payout");
    applyStimulus("abort_a", 1, 3, 1, 0, 2 + MC + 1 + 1);
    applyStimulus("post_abort_c", 3, 0, 1, 0, 0);

    $display("[TB] randomized transactions");
    for (int it = 0; it < 24; it++) begin
      prod   = $urandom_range(1, 3);
      change = $urandom_range(0, 3);
      drop_d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, DT);
      extra  = $urandom_range(0, 7);
      if (!m_jam && m_stock[prod] != 0 && drop_d == 0 && $urandom_range(0, 1) == 1) extra |= 8;
      applyStimulus($sformatf("rand%0d", it), prod, change, drop_d, extra, 0);
      if ($urandom_range(0, 3) == 0 || m_jam)
        idleCycle($sformatf("rand_idle%0d", it), $urandom_range(0, 3), m_jam && ($urandom_range(0, 1) == 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
